// File: rtl/unique0_code_decoder.sv
// unique0_code_decoder: streaming classifier that matches each accepted code
// against a programmable value/mask table and registers a hit vector, the
// winning entry index and default/overlap flags behind a valid/ready stage.
// Saturating counters track how many default and overlap results were accepted.
module unique0_code_decoder #(
  parameter int CODE_W      = 3,
  parameter int NUM_ENTRIES = 8,
  parameter int PRIORITY_EN = 0,
  parameter int CNT_W       = 8,
  localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [CODE_W-1:0]      cfg_value,
  input  logic [CODE_W-1:0]      cfg_mask,
  input  logic                   cfg_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CODE_W-1:0]      in_code,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_ENTRIES-1:0] out_hit,
  output logic [IDX_W-1:0]       out_index,
  output logic                   out_default,
  output logic                   out_overlap,
  output logic [CNT_W-1:0]       default_cnt,
  output logic [CNT_W-1:0]       overlap_cnt,
  input  logic                   clr_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state, state_nxt;

  logic [CODE_W-1:0]      tbl_value [NUM_ENTRIES];
  logic [CODE_W-1:0]      tbl_mask  [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] tbl_en;

  logic                   accept;
  logic                   idx_ok;
  logic [NUM_ENTRIES-1:0] hit_raw_p0;
  logic [NUM_ENTRIES-1:0] hit_low_p0;
  logic [IDX_W-1:0]       low_idx_p0;
  logic                   multi_p0;
  logic [NUM_ENTRIES-1:0] hit_p0;
  logic [IDX_W-1:0]       index_p0;
  logic                   default_p0;
  logic                   overlap_p0;

  logic [NUM_ENTRIES-1:0] hit_p1;
  logic [IDX_W-1:0]       index_p1;
  logic                   default_p1;
  logic                   overlap_p1;
  logic                   vld_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Writes to indices beyond the table are dropped; only needed when the
  // index width can address more entries than exist.
  if (NUM_ENTRIES < (2 ** IDX_W)) begin : g_idx_chk
    assign idx_ok = (cfg_idx < IDX_W'(NUM_ENTRIES));
  end else begin : g_idx_all
    assign idx_ok = 1'b1;
  end

  assign vld_p1   = (state == FULL);
  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

  // Match table: a write applies from the next edge, so a code accepted in the
  // same cycle still sees the old entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tbl_value[i] <= '0;
        tbl_mask[i]  <= '0;
      end
      tbl_en <= '0;
    end else if (cfg_we && idx_ok) begin
      tbl_value[cfg_idx] <= cfg_value;
      tbl_mask[cfg_idx]  <= cfg_mask;
      tbl_en[cfg_idx]    <= cfg_en;
    end
  end

  // ---- stage p0: combinational match and classification of in_code ----
  always_comb begin
    hit_raw_p0 = '0;
    low_idx_p0 = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      hit_raw_p0[i] = tbl_en[i] && (((in_code ^ tbl_value[i]) & tbl_mask[i]) == '0);
    end
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (hit_raw_p0[i]) low_idx_p0 = IDX_W'(i);
    end
    // Isolate the lowest set bit; any bit left after clearing it means overlap.
    hit_low_p0 = hit_raw_p0 & (~hit_raw_p0 + NUM_ENTRIES'(1));
    multi_p0   = |(hit_raw_p0 & (hit_raw_p0 - NUM_ENTRIES'(1)));
    default_p0 = (hit_raw_p0 == '0);
    overlap_p0 = multi_p0;
    hit_p0     = hit_raw_p0;
    index_p0   = low_idx_p0;
    if (multi_p0) begin
      if (PRIORITY_EN != 0) begin
        hit_p0   = hit_low_p0;
        index_p0 = low_idx_p0;
      end else begin
        // No winner in unique0 mode: raw vector passes through, index forced 0.
        hit_p0   = hit_raw_p0;
        index_p0 = '0;
      end
    end
  end

  // Output occupancy state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Output occupancy next state: refill keeps FULL, drain alone empties
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (out_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // ---- stage p1: registered result, loaded only on accept so it holds under stall ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_p1     <= '0;
      index_p1   <= '0;
      default_p1 <= 1'b0;
      overlap_p1 <= 1'b0;
    end else if (accept) begin
      hit_p1     <= hit_p0;
      index_p1   <= index_p0;
      default_p1 <= default_p0;
      overlap_p1 <= overlap_p0;
    end
  end

  // Saturating statistics, bumped once per accepted code; clear has priority
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      default_cnt <= '0;
      overlap_cnt <= '0;
    end else if (accept) begin
      if (default_p0) default_cnt <= sat_inc(default_cnt);
      if (overlap_p0) overlap_cnt <= sat_inc(overlap_cnt);
    end
  end

  assign out_valid   = vld_p1;
  assign out_hit     = hit_p1;
  assign out_index   = index_p1;
  assign out_default = default_p1;
  assign out_overlap = overlap_p1;

endmodule

// File: tb/tb_unique0_code_decoder.sv
// Bench for unique0_code_decoder: one instance per mode (unique0 and priority)
// driven in lockstep; expected results come from a table model and are queued
// on accept, then checked against whatever the DUTs present while out_valid.
module tb_unique0_code_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [2:0] cfg_value = '0;
  logic [2:0] cfg_mask = '0;
  logic       cfg_en = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = '0;
  logic       out_ready = 1'b1;
  logic       clr_cnt = 1'b0;

  logic       in_ready0, out_valid0, out_default0, out_overlap0;
  logic [7:0] out_hit0, default_cnt0, overlap_cnt0;
  logic [2:0] out_index0;
  logic       in_ready1, out_valid1, out_default1, out_overlap1;
  logic [7:0] out_hit1, default_cnt1, overlap_cnt1;
  logic [2:0] out_index1;

  unique0_code_decoder #(.CODE_W(3), .NUM_ENTRIES(8), .PRIORITY_EN(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_value(cfg_value),
    .cfg_mask(cfg_mask), .cfg_en(cfg_en), .in_valid(in_valid), .in_ready(in_ready0),
    .in_code(in_code), .out_valid(out_valid0), .out_ready(out_ready), .out_hit(out_hit0),
    .out_index(out_index0), .out_default(out_default0), .out_overlap(out_overlap0),
    .default_cnt(default_cnt0), .overlap_cnt(overlap_cnt0), .clr_cnt(clr_cnt));

  unique0_code_decoder #(.CODE_W(3), .NUM_ENTRIES(8), .PRIORITY_EN(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_value(cfg_value),
    .cfg_mask(cfg_mask), .cfg_en(cfg_en), .in_valid(in_valid), .in_ready(in_ready1),
    .in_code(in_code), .out_valid(out_valid1), .out_ready(out_ready), .out_hit(out_hit1),
    .out_index(out_index1), .out_default(out_default1), .out_overlap(out_overlap1),
    .default_cnt(default_cnt1), .overlap_cnt(overlap_cnt1), .clr_cnt(clr_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] hit0;
    logic [2:0] idx0;
    logic [7:0] hit1;
    logic [2:0] idx1;
    logic       def;
    logic       ovl;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [2:0] m_val  [8];
  logic [2:0] m_mask [8];
  logic       m_en   [8];
  int         m_def = 0;
  int         m_ovl = 0;

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  function automatic exp_t model(input logic [2:0] code);
    exp_t e;
    int n = 0;
    int first = -1;
    logic [7:0] raw = '0;
    for (int i = 0; i < 8; i++) begin
      if (m_en[i] && (((code ^ m_val[i]) & m_mask[i]) == 3'b000)) begin
        raw[i] = 1'b1;
        n++;
        if (first < 0) first = i;
      end
    end
    e.def = (n == 0);
    e.ovl = (n > 1);
    e.hit0 = '0; e.idx0 = '0; e.hit1 = '0; e.idx1 = '0;
    if (n == 1) begin
      e.hit0 = raw; e.hit1 = raw;
      e.idx0 = 3'(first); e.idx1 = 3'(first);
    end else if (n > 1) begin
      e.hit0 = raw;
      e.hit1 = 8'b1 << first;
      e.idx1 = 3'(first);
    end
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_val[i] = '0; m_mask[i] = '0; m_en[i] = 1'b0;
    end
    m_def = 0;
    m_ovl = 0;
  endtask

  // Scoreboard: any presented result must equal the queue head; pop on transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid0) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got hit=%b idx=%0d with no expected result", out_hit0, out_index0);
      end else begin
        mon_e = q[0];
        if ({out_hit0, out_index0, out_default0, out_overlap0} !== {mon_e.hit0, mon_e.idx0, mon_e.def, mon_e.ovl} ||
            {out_valid1, out_hit1, out_index1, out_default1, out_overlap1} !== {1'b1, mon_e.hit1, mon_e.idx1, mon_e.def, mon_e.ovl}) begin
          n_bad++;
          $display("FAIL result: got u0 hit=%b idx=%0d def=%b ovl=%b / pr v=%b hit=%b idx=%0d, want u0 hit=%b idx=%0d def=%b ovl=%b / pr hit=%b idx=%0d",
                   out_hit0, out_index0, out_default0, out_overlap0, out_valid1, out_hit1, out_index1,
                   mon_e.hit0, mon_e.idx0, mon_e.def, mon_e.ovl, mon_e.hit1, mon_e.idx1);
        end
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // Present a code (optionally with a same-cycle table write / counter clear on
  // the first edge) and hold it until accepted. Ends at posedge+1.
  task automatic send_x(input logic [2:0] code, input bit do_cfg, input logic [2:0] ci,
                        input logic [2:0] cv, input logic [2:0] cm, input bit ce, input bit clr);
    bit done = 0;
    exp_t e;
    in_valid = 1'b1; in_code = code;
    cfg_we = do_cfg; cfg_idx = ci; cfg_value = cv; cfg_mask = cm; cfg_en = ce;
    clr_cnt = clr;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready0) begin
        e = model(code);
        q.push_back(e);
        if (e.def) m_def = sat(m_def);
        if (e.ovl) m_ovl = sat(m_ovl);
        done = 1;
      end
      if (clr_cnt) begin m_def = 0; m_ovl = 0; end
      if (cfg_we) begin m_val[ci] = cv; m_mask[ci] = cm; m_en[ci] = ce; end
      @(posedge clk); #1;
      cfg_we = 1'b0; clr_cnt = 1'b0;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: code %0d got in_ready=0 want accept within 50 cycles", code);
    end
  endtask

  task automatic send(input logic [2:0] code);
    send_x(code, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic cfg_write(input logic [2:0] i, input logic [2:0] v, input logic [2:0] m, input bit e);
    cfg_we = 1'b1; cfg_idx = i; cfg_value = v; cfg_mask = m; cfg_en = e;
    @(posedge clk);
    m_val[i] = v; m_mask[i] = m; m_en[i] = e;
    #1 cfg_we = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 50 && q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d results outstanding want 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid0, out_hit0, out_index0, out_default0, out_overlap0, default_cnt0, overlap_cnt0} !== 31'd0) begin
      n_bad++;
      $display("FAIL reset_u0: got v=%b hit=%b idx=%0d def=%b ovl=%b dc=%0d oc=%0d want all 0",
               out_valid0, out_hit0, out_index0, out_default0, out_overlap0, default_cnt0, overlap_cnt0);
    end
    n_cmp++;
    if ({out_valid1, out_hit1, out_index1, out_default1, out_overlap1, default_cnt1, overlap_cnt1} !== 31'd0) begin
      n_bad++;
      $display("FAIL reset_pr: got v=%b hit=%b idx=%0d dc=%0d oc=%0d want all 0",
               out_valid1, out_hit1, out_index1, default_cnt1, overlap_cnt1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({in_ready0, in_ready1} !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b%b want 11", in_ready0, in_ready1);
    end
  endtask

  task automatic setup_table();
    for (int i = 0; i < 8; i++) cfg_write(3'(i), 3'(i), 3'b111, i != 4);
  endtask

  task automatic test_default();
    send(3'd4);
    n_cmp++;
    if (default_cnt0 !== 8'd1) begin
      n_bad++;
      $display("FAIL default_cnt: got %0d want 1", default_cnt0);
    end
    wait_drain();
  endtask

  task automatic test_single();
    send(3'd5);
    n_cmp++;
    if (out_valid0 !== 1'b1 || out_hit0 !== 8'b0010_0000 || out_index0 !== 3'd5) begin
      n_bad++;
      $display("FAIL single_latency: got v=%b hit=%b idx=%0d want v=1 hit=00100000 idx=5",
               out_valid0, out_hit0, out_index0);
    end
    wait_drain();
  endtask

  task automatic test_overlap();
    cfg_write(3'd0, 3'b100, 3'b100, 1'b1);
    send(3'd5);
    n_cmp++;
    if (out_overlap0 !== 1'b1 || out_hit0 !== 8'b0010_0001 || overlap_cnt0 !== 8'd1 || out_index1 !== 3'd0) begin
      n_bad++;
      $display("FAIL overlap: got ovl=%b hit=%b oc=%0d pr_idx=%0d want ovl=1 hit=00100001 oc=1 pr_idx=0",
               out_overlap0, out_hit0, overlap_cnt0, out_index1);
    end
    wait_drain();
    cfg_write(3'd0, 3'd0, 3'b111, 1'b1);
    cfg_write(3'd3, 3'b011, 3'b011, 1'b1);
    send(3'd7);
    n_cmp++;
    if (out_hit0 !== 8'b1000_1000 || out_index0 !== 3'd0 || out_hit1 !== 8'b0000_1000 || out_index1 !== 3'd3) begin
      n_bad++;
      $display("FAIL overlap_prio: got u0 hit=%b idx=%0d pr hit=%b idx=%0d want 10001000/0 and 00001000/3",
               out_hit0, out_index0, out_hit1, out_index1);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    fork
      begin
        for (int c = 0; c < 8; c++) send(3'(c));
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          n_cmp++;
          if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_ready: got in_ready=%b out_valid=%b want 0/1", in_ready0, out_valid0);
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    n_cmp++;
    if (default_cnt0 !== 8'(m_def) || overlap_cnt0 !== 8'(m_ovl)) begin
      n_bad++;
      $display("FAIL b2b_counts: got dc=%0d oc=%0d want dc=%0d oc=%0d", default_cnt0, overlap_cnt0, m_def, m_ovl);
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 260; k++) send(3'd4);
    n_cmp++;
    if (default_cnt0 !== 8'd255 || default_cnt1 !== 8'd255) begin
      n_bad++;
      $display("FAIL saturate: got %0d/%0d want 255", default_cnt0, default_cnt1);
    end
    send_x(3'd4, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    n_cmp++;
    if (default_cnt0 !== 8'd0 || overlap_cnt0 !== 8'd0) begin
      n_bad++;
      $display("FAIL clr_wins: got dc=%0d oc=%0d want 0/0", default_cnt0, overlap_cnt0);
    end
    send(3'd4);
    n_cmp++;
    if (default_cnt0 !== 8'd1) begin
      n_bad++;
      $display("FAIL count_after_clr: got %0d want 1", default_cnt0);
    end
    wait_drain();
  endtask

  task automatic test_cfg_same_cycle();
    send_x(3'd2, 1'b1, 3'd2, 3'd2, 3'b111, 1'b0, 1'b0);
    n_cmp++;
    if (out_hit0 !== 8'b0000_0100 || out_index0 !== 3'd2 || out_default0 !== 1'b0) begin
      n_bad++;
      $display("FAIL cfg_old_table: got hit=%b idx=%0d def=%b want 00000100/2/0", out_hit0, out_index0, out_default0);
    end
    send(3'd2);
    n_cmp++;
    if (out_default0 !== 1'b1 || out_hit0 !== 8'd0) begin
      n_bad++;
      $display("FAIL cfg_new_table: got def=%b hit=%b want 1/00000000", out_default0, out_hit0);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(3'd5);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    q.delete();
    model_clear();
    out_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid0 !== 1'b0 || default_cnt0 !== 8'd0 || overlap_cnt0 !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_mid: got v=%b dc=%0d oc=%0d want 0/0/0", out_valid0, default_cnt0, overlap_cnt0);
    end
    send(3'd5);
    n_cmp++;
    if (out_default0 !== 1'b1 || default_cnt0 !== 8'd1) begin
      n_bad++;
      $display("FAIL table_cleared: got def=%b dc=%0d want 1/1", out_default0, default_cnt0);
    end
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    setup_table();
    test_default();
    test_single();
    test_overlap();
    test_back_to_back();
    test_saturate();
    test_cfg_same_cycle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
